// File: rtl/airlock_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | airlock_pkg : shared state encoding, default timing and timer sizing        |
// | Revision    : 1.0                                                           |
// +----------------------------------------------------------------------------+
package airlock_pkg;

  localparam int unsigned DOOR_CYCLES_DEFAULT = 4;
  localparam int unsigned EVAC_CYCLES_DEFAULT = 8;

  typedef enum logic [2:0] {
    ST_IDLE_EVAC  = 3'd0,
    ST_OUTER_OPEN = 3'd1,
    ST_PRESSURIZE = 3'd2,
    ST_INNER_OPEN = 3'd3,
    ST_IDLE_PRESS = 3'd4,
    ST_EVACUATE   = 3'd5
  } state_e;

  // Wide enough to hold the larger of the two phase lengths.
  function automatic int unsigned timer_width(input int unsigned door_cycles,
                                               input int unsigned evac_cycles);
    int unsigned longest;
    longest = (door_cycles > evac_cycles) ? door_cycles : evac_cycles;
    return (longest < 1) ? 1 : $clog2(longest + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/airlock_timer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | airlock_timer : loadable down-counter that stops at zero                    |
// | Revision      : 1.0                                                         |
// +----------------------------------------------------------------------------+
module airlock_timer
  import airlock_pkg::*;
#(
  parameter int unsigned WIDTH = timer_width(DOOR_CYCLES_DEFAULT, EVAC_CYCLES_DEFAULT)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] value_i,
  output logic             done_o
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = value_i;
    end else if (count_q != '0) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign done_o = (count_q == '0);

endmodule
`default_nettype wire

// File: rtl/airlock_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | airlock_ctrl : two-door chamber sequencer with request latching, door       |
// |                unlock timing, pressurization handshake and evacuation       |
// | Revision     : 1.0                                                          |
// +----------------------------------------------------------------------------+
module airlock_ctrl
  import airlock_pkg::*;
#(
  parameter int unsigned DOOR_CYCLES = DOOR_CYCLES_DEFAULT,
  parameter int unsigned EVAC_CYCLES = EVAC_CYCLES_DEFAULT
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic arrive_i,
  input  logic depart_i,
  input  logic outer_closed_i,
  input  logic inner_closed_i,
  input  logic pressurized_i,
  output logic countdown_o,
  output logic outer_open_o,
  output logic inner_open_o,
  output logic occupied_o,
  output logic busy_o
);

  localparam int unsigned TW = timer_width(DOOR_CYCLES, EVAC_CYCLES);
  localparam logic [TW-1:0] C_DOOR_LOAD = TW'(DOOR_CYCLES);
  // Evacuation leaves on the cycle the timer reads zero, which is itself one of its cycles.
  localparam logic [TW-1:0] C_EVAC_LOAD = TW'(EVAC_CYCLES - 1);

  state_e state_q;
  state_e state_d;
  logic   occ_q;
  logic   occ_d;
  logic   arr_pend_q;
  logic   arr_pend_d;
  logic   dep_pend_q;
  logic   dep_pend_d;
  logic   w_arr_clr;
  logic   w_dep_clr;

  logic          w_tmr_load;
  logic [TW-1:0] w_tmr_value;
  logic          w_tmr_done;

  airlock_timer #(
    .WIDTH (TW)
  ) u_timer (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .load_i  (w_tmr_load),
    .value_i (w_tmr_value),
    .done_o  (w_tmr_done)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= ST_IDLE_EVAC;
      occ_q      <= 1'b0;
      arr_pend_q <= 1'b0;
      dep_pend_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      occ_q      <= occ_d;
      arr_pend_q <= arr_pend_d;
      dep_pend_q <= dep_pend_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    occ_d     = occ_q;
    w_arr_clr = 1'b0;
    w_dep_clr = 1'b0;

    case (state_q)
      ST_IDLE_EVAC: begin
        if (arr_pend_q) begin
          state_d = ST_OUTER_OPEN;
        end else if (dep_pend_q) begin
          state_d = ST_PRESSURIZE;
        end
      end
      ST_OUTER_OPEN: begin
        if (w_tmr_done && outer_closed_i) begin
          occ_d = ~occ_q;
          if (occ_q) begin
            state_d = ST_IDLE_EVAC;
          end else begin
            w_arr_clr = 1'b1;
            state_d   = ST_PRESSURIZE;
          end
        end
      end
      ST_PRESSURIZE: begin
        if (pressurized_i) begin
          state_d = occ_q ? ST_INNER_OPEN : ST_IDLE_PRESS;
        end
      end
      ST_INNER_OPEN: begin
        if (w_tmr_done && inner_closed_i) begin
          occ_d = ~occ_q;
          if (occ_q) begin
            state_d = ST_IDLE_PRESS;
          end else begin
            w_dep_clr = 1'b1;
            state_d   = ST_EVACUATE;
          end
        end
      end
      ST_IDLE_PRESS: begin
        if (dep_pend_q) begin
          state_d = ST_INNER_OPEN;
        end else if (arr_pend_q) begin
          state_d = ST_EVACUATE;
        end
      end
      ST_EVACUATE: begin
        if (w_tmr_done) begin
          state_d = occ_q ? ST_OUTER_OPEN : ST_IDLE_EVAC;
        end
      end
      default: begin
        state_d = ST_IDLE_EVAC;
      end
    endcase

    // A request in the same cycle as its clear keeps the pend set.
    arr_pend_d = arrive_i | (arr_pend_q & ~w_arr_clr);
    dep_pend_d = depart_i | (dep_pend_q & ~w_dep_clr);
  end

  // The timer is loaded on the edge that enters a timed state.
  always_comb begin
    w_tmr_load  = 1'b0;
    w_tmr_value = C_DOOR_LOAD;
    if (state_d != state_q) begin
      case (state_d)
        ST_OUTER_OPEN, ST_INNER_OPEN: begin
          w_tmr_load  = 1'b1;
          w_tmr_value = C_DOOR_LOAD;
        end
        ST_EVACUATE: begin
          w_tmr_load  = 1'b1;
          w_tmr_value = C_EVAC_LOAD;
        end
        default: begin
          w_tmr_load = 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    countdown_o  = (state_q == ST_PRESSURIZE);
    outer_open_o = (state_q == ST_OUTER_OPEN) && !w_tmr_done;
    inner_open_o = (state_q == ST_INNER_OPEN) && !w_tmr_done;
    occupied_o   = occ_q;
    busy_o       = (state_q != ST_IDLE_EVAC) && (state_q != ST_IDLE_PRESS);
  end

  a_doors_exclusive : assert property (@(posedge clk_i) !(outer_open_o && inner_open_o));

endmodule
`default_nettype wire

// File: tb/tb_airlock_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// +----------------------------------------------------------------------------+
// | tb_airlock_ctrl : service-sequence reference model with output scoreboard  |
// | Revision        : 1.0                                                      |
// +----------------------------------------------------------------------------+
module tb_airlock_ctrl;

  localparam int DOOR = 4;
  localparam int EVAC = 8;

  logic clk_i          = 1'b0;
  logic rst_i          = 1'b1;
  logic arrive_i       = 1'b0;
  logic depart_i       = 1'b0;
  logic outer_closed_i = 1'b1;
  logic inner_closed_i = 1'b1;
  logic pressurized_i  = 1'b0;
  logic countdown_o;
  logic outer_open_o;
  logic inner_open_o;
  logic occupied_o;
  logic busy_o;

  airlock_ctrl #(
    .DOOR_CYCLES (DOOR),
    .EVAC_CYCLES (EVAC)
  ) dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .arrive_i       (arrive_i),
    .depart_i       (depart_i),
    .outer_closed_i (outer_closed_i),
    .inner_closed_i (inner_closed_i),
    .pressurized_i  (pressurized_i),
    .countdown_o    (countdown_o),
    .outer_open_o   (outer_open_o),
    .inner_open_o   (inner_open_o),
    .occupied_o     (occupied_o),
    .busy_o         (busy_o)
  );

  always #5 clk_i = ~clk_i;

  // Model state: which side the chamber is equalised to, occupant, pending requests.
  bit side_press = 1'b0;
  bit m_occ      = 1'b0;
  bit m_arr      = 1'b0;
  bit m_dep      = 1'b0;
  bit aborted    = 1'b0;
  bit rand_en    = 1'b0;
  bit force_a    = 1'b0;
  bit force_d    = 1'b0;
  bit g_inject   = 1'b0;
  int g_hold     = 0;
  int g_lat      = 3;
  int g_abort    = -1;
  int cyc_n      = 0;

  logic [4:0] exp_q[$];
  int total = 0;
  int bad   = 0;
  bit mon_en = 1'b0;
  logic [4:0] act_v;
  logic [4:0] exp_v;

  // Output vector order: {countdown, outer_open, inner_open, occupied, busy}
  always @(negedge clk_i) begin
    if (mon_en) begin
      act_v = {countdown_o, outer_open_o, inner_open_o, occupied_o, busy_o};
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL scoreboard_empty cycle=%0d actual=%b", cyc_n, act_v);
      end else begin
        exp_v = exp_q.pop_front();
        if (act_v !== exp_v) begin
          bad++;
          $display("FAIL outputs cycle=%0d actual{cd,oo,io,occ,busy}=%b required=%b",
                   cyc_n, act_v, exp_v);
        end
      end
    end
  end

  initial begin
    #800000;
    $display("FAIL watchdog cycle=%0d actual=running required=finished", cyc_n);
    $fatal(1, "watchdog expired");
  end

  function automatic bit rb();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic bit rreq();
    return rand_en && ($urandom_range(0, 11) == 0);
  endfunction

  // One clock: drive inputs, push what the outputs must be this cycle, then
  // fold this cycle's requests/clears into the model after the edge.
  task automatic cyc(input bit cd, input bit oo, input bit io, input bit bz,
                     input bit oc, input bit ic, input bit pr,
                     input bit clr_a, input bit clr_d, input bit rst);
    bit a;
    bit d;
    a = force_a | rreq();
    d = force_d | rreq();
    force_a = 1'b0;
    force_d = 1'b0;
    arrive_i       = a;
    depart_i       = d;
    outer_closed_i = oc;
    inner_closed_i = ic;
    pressurized_i  = pr;
    rst_i          = rst;
    exp_q.push_back({cd, oo, io, m_occ, bz});
    @(posedge clk_i);
    #1;
    cyc_n++;
    if (rst) begin
      m_arr = 1'b0;
      m_dep = 1'b0;
      m_occ = 1'b0;
    end else begin
      if (clr_a) m_arr = 1'b0;
      if (clr_d) m_dep = 1'b0;
      if (a) m_arr = 1'b1;
      if (d) m_dep = 1'b1;
    end
  endtask

  // Door phase: DOOR unlocked cycles, 'hold' cycles with the door still ajar,
  // then one cycle where it reports shut and the occupant changes side.
  task automatic door(input bit outer);
    bit was_occ;
    int hold;
    was_occ = m_occ;
    hold    = rand_en ? int'($urandom_range(0, 3)) : g_hold;
    for (int i = 0; i < DOOR; i++) cyc(0, outer, !outer, 1, rb(), rb(), rb(), 0, 0, 0);
    for (int i = 0; i < hold; i++)
      cyc(0, 0, 0, 1, outer ? 1'b0 : rb(), outer ? rb() : 1'b0, rb(), 0, 0, 0);
    cyc(0, 0, 0, 1, outer ? 1'b1 : rb(), outer ? rb() : 1'b1, rb(),
        outer && !was_occ, !outer && !was_occ, 0);
    m_occ = !was_occ;
  endtask

  task automatic pressurize();
    int lat;
    int abort_at;
    lat = rand_en ? (($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 5)) : 3) : g_lat;
    abort_at = g_abort;
    if (rand_en) abort_at = (lat > 0 && $urandom_range(0, 15) == 0) ? int'($urandom_range(0, lat - 1)) : -1;
    for (int i = 0; i < lat; i++) begin
      if (g_inject && i == 0) begin
        force_a = 1'b1;
        force_d = 1'b1;
      end
      if (i == abort_at) begin
        cyc(1, 0, 0, 1, rb(), rb(), 0, 0, 0, 1);
        aborted    = 1'b1;
        side_press = 1'b0;
        return;
      end
      cyc(1, 0, 0, 1, rb(), rb(), 0, 0, 0, 0);
    end
    cyc(1, 0, 0, 1, rb(), rb(), 1, 0, 0, 0);
  endtask

  task automatic evacuate();
    for (int i = 0; i < EVAC; i++) cyc(0, 0, 0, 1, rb(), rb(), rb(), 0, 0, 0);
  endtask

  // One idle cycle, then whatever service the pending requests call for.
  task automatic step();
    bit a;
    bit d;
    a = m_arr;
    d = m_dep;
    aborted = 1'b0;
    cyc(0, 0, 0, 0, rb(), rb(), rb(), 0, 0, 0);
    if (!side_press) begin
      if (a) begin
        door(1'b1);
        pressurize();
        if (!aborted) begin
          door(1'b0);
          side_press = 1'b1;
        end
      end else if (d) begin
        pressurize();
        if (!aborted) side_press = 1'b1;
      end
    end else begin
      if (d) begin
        door(1'b0);
        evacuate();
        door(1'b1);
        side_press = 1'b0;
      end else if (a) begin
        evacuate();
        side_press = 1'b0;
      end
    end
  endtask

  initial begin
    rst_i = 1'b1;
    repeat (2) @(posedge clk_i);
    #1;
    rst_i  = 1'b0;
    mon_en = 1'b1;

    step();                                      // reset values
    force_a = 1'b1; step(); step();              // arrival
    force_d = 1'b1; step(); step();              // departure
    force_d = 1'b1; step(); step(); step();      // pressurize reposition, then departure
    force_a = 1'b1; step(); step();              // arrival into IDLE_PRESS
    force_a = 1'b1; step(); step(); step();      // evacuate reposition, then arrival
    force_d = 1'b1; step(); step();              // departure back to IDLE_EVAC
    force_a = 1'b1; force_d = 1'b1;
    step(); step(); step();                      // simultaneous: arrival then departure
    g_hold = 10;
    force_a = 1'b1; step(); step();              // doors held ajar 10 cycles
    g_hold = 0;
    g_lat = 6; g_abort = 2; g_inject = 1'b1;
    force_a = 1'b1; step(); step(); step();      // reset during PRESSURIZE
    g_lat = 3; g_abort = -1; g_inject = 1'b0;
    repeat (4) step();                           // pendings must be gone

    rand_en = 1'b1;
    while (cyc_n < 4000) step();
    rand_en = 1'b0;
    rst_i   = 1'b0;
    mon_en  = 1'b0;

    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain actual=%0d required=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/airlock_ctrl.md
# airlock_ctrl

Sequencing controller for the two-door pressurization chamber. Latches diver arrive/depart requests, drives the door unlocks, and issues the `countdown` request to the downstream `countdown_FP` stage. Consumes that stage's `pressurized` status to decide when the inner door may open. Also runs its own evacuation timer, and guarantees the two doors are never unlocked together.

## Interface
- DOOR_CYCLES, 4: cycles a door unlock is held before the controller waits for the door-closed sensor (≥1)
- EVAC_CYCLES, 8: cycles the chamber takes to evacuate to water pressure (≥1)
- Clock  in  1  system clock, rising edge
- Reset  in  1  synchronous, active-high
- arrive  in  1  diver outside requests entry (one-cycle pulse or level)
- depart  in  1  diver inside requests exit (one-cycle pulse or level)
- outer_closed  in  1  outer door sensor, 1 = shut
- inner_closed  in  1  inner door sensor, 1 = shut
- pressurized  in  1  from `countdown_FP`: chamber at interior pressure
- countdown  out  1  to `countdown_FP`: pressurization request, held high for the whole of PRESSURIZE
- outer_open  out  1  outer door unlock
- inner_open  out  1  inner door unlock
- occupied  out  1  diver currently in chamber
- busy  out  1  state is not IDLE_EVAC or IDLE_PRESS

## Operation
- **State register:** states IDLE_EVAC, OUTER_OPEN, PRESSURIZE, INNER_OPEN, IDLE_PRESS, EVACUATE.
- **Other registers:**
  - `occ` (drives `occupied`)
  - `arr_pend`, `dep_pend`: set on any cycle the input is 1, cleared only as listed below.
- **Reset:** state IDLE_EVAC, occ=0, both pendings 0, timer 0, all outputs 0.
- **IDLE_EVAC:**
  - arr_pend → OUTER_OPEN.
  - Else dep_pend → PRESSURIZE. This is an empty reposition; occ stays 0.
  - Arrive has priority.
- **OUTER_OPEN:**
  - On entry, load the timer with DOOR_CYCLES. outer_open=1 while timer≠0.
  - After expiry, wait for outer_closed=1, then:
    - occ=0 (diver entering): set occ=1, clear arr_pend → PRESSURIZE.
    - occ=1 (diver leaving): set occ=0 → IDLE_EVAC.
- **PRESSURIZE:** countdown=1. On the first cycle pressurized=1: occ ? INNER_OPEN : IDLE_PRESS.
- **INNER_OPEN:**
  - Same timer and door-closed rule as OUTER_OPEN, using inner_closed.
  - occ=1: set occ=0 → IDLE_PRESS.
  - occ=0: set occ=1, clear dep_pend → EVACUATE.
- **IDLE_PRESS:**
  - dep_pend → INNER_OPEN.
  - Else arr_pend → EVACUATE. This is an empty reposition.
  - Depart has priority.
- **EVACUATE:** on entry, load the timer with EVAC_CYCLES. On expiry: occ ? OUTER_OPEN : IDLE_EVAC.
- **Pending requests:**
  - A request already pending is unaffected by re-assertion.
  - A request arriving in the cycle its pend is cleared leaves the pend set (set wins).
- **Safety invariants:**
  - outer_open and inner_open are never both 1.
  - outer_open=1 only in OUTER_OPEN.
  - countdown=1 only in PRESSURIZE.
- **Reset mid-operation:** any state returns to IDLE_EVAC on the next edge, and all unlocks drop.

## Timing
- All outputs are decoded from registered state/timer only. There is no combinational input→output path.
- **Request to unlock:** request sampled at edge t → state changes at edge t+1 → outer_open high during cycles t+1 … t+DOOR_CYCLES.
- **Door close:** closed sensor sampled high at the first edge after the timer expires → next state takes effect at that edge. A door already shut costs no extra cycles.
- **Pressurization:** countdown rises on PRESSURIZE entry. It falls on the edge that samples pressurized=1, so there is one cycle of overlap.
- **Evacuation:** exactly EVAC_CYCLES cycles in EVACUATE.
- **Timer:** width $clog2(max(DOOR_CYCLES, EVAC_CYCLES)+1). It decrements to 0 and holds.

## Structure
- **Shared package `airlock_pkg`:** state enum (3-bit encoding), DOOR_CYCLES/EVAC_CYCLES defaults, timer-width function.
- **Sub-module `airlock_timer`:** loadable down-counter. Ports: Clock, Reset, load, value, done. It is shared by the door and evacuation phases.

## Test plan
Settings: DOOR_CYCLES=4, EVAC_CYCLES=8. The `countdown_FP` model returns pressurized 3 cycles after countdown rises.

- **Reset values:** Reset high 2 cycles → all outputs 0, busy=0.
- **Arrival:** arrive pulse in IDLE_EVAC, outer_closed=1 after the timer, inner_closed=1 after the timer.
  - Expected: outer_open 4 cycles → countdown high until pressurized → inner_open 4 cycles → IDLE_PRESS, occupied=0.
  - Doors never overlap.
- **Departure:** depart in IDLE_PRESS → inner_open 4 cycles → occupied=1 → 8 cycles EVACUATE → outer_open 4 cycles → IDLE_EVAC, occupied=0.
- **Reposition:**
  - depart in IDLE_EVAC → countdown, no door opens → IDLE_PRESS → then the full departure sequence.
  - arrive in IDLE_PRESS → 8-cycle evacuate → then the full arrival sequence.
- **Simultaneous requests:**
  - arrive+depart in the same cycle in IDLE_EVAC → arrival served first, depart stays pending, departure follows immediately from IDLE_PRESS.
  - Door held open (outer_closed=0 for 10 cycles after the timer) → state holds, outer_open=0.
- **Reset mid-operation:** Reset asserted during PRESSURIZE → countdown=0 the next cycle, state IDLE_EVAC, pendings cleared.
